// File: rtl/rat_ckpt_ctrl_pkg.sv
// Shared rename-stage definitions for the RAT checkpoint controller.
//   C_NUM       : number of RAT checkpoints (power of two, >= 2)
//   INSTR_COUNT : rename group width
//   ckpt_id_t   : checkpoint identifier
//   resolve_t   : branch resolution bundle coming back from execute
package rat_ckpt_ctrl_pkg;

   localparam int unsigned C_NUM       = 4;
   localparam int unsigned INSTR_COUNT = 2;
   localparam int unsigned CKPT_ID_W   = $clog2(C_NUM);

   typedef logic [CKPT_ID_W-1:0] ckpt_id_t;

   typedef struct packed {
      logic     valid;
      ckpt_id_t id;
      logic     mispredict;
   } resolve_t;

endpackage

// File: rtl/rat_ckpt_ctrl_branch_prefix_find.sv
// Locates the first two valid branches of a rename group and derives the
// accept thermometers used by the checkpoint controller.
//   valid        in  : valid slots, slot 0 oldest
//   is_branch    in  : slot holds a branch
//   b0_oh        out : one-hot of the first valid branch (0 if none)
//   b1_oh        out : one-hot of the second valid branch (0 if none)
//   accept_take  out : valid slots strictly before b1 (all valid if no b1)
//   accept_stall out : valid slots strictly before b0 (all valid if no b0)
module rat_ckpt_ctrl_branch_prefix_find
   import rat_ckpt_ctrl_pkg::*;
#(
   parameter int unsigned INSTR_COUNT = rat_ckpt_ctrl_pkg::INSTR_COUNT
) (
   input  logic [INSTR_COUNT-1:0] valid,
   input  logic [INSTR_COUNT-1:0] is_branch,
   output logic [INSTR_COUNT-1:0] b0_oh,
   output logic [INSTR_COUNT-1:0] b1_oh,
   output logic [INSTR_COUNT-1:0] accept_take,
   output logic [INSTR_COUNT-1:0] accept_stall
);

   logic [INSTR_COUNT-1:0] vbr;
   logic [INSTR_COUNT-1:0] pre_b0;
   logic [INSTR_COUNT-1:0] pre_b1;
   logic                   seen0;
   logic                   seen1;

   assign vbr = valid & is_branch;

   // Scan oldest to youngest; the prefix masks are updated after the slot's
   // own branch is recorded so that they exclude the branch slot itself.
   always_comb begin
      b0_oh  = '0;
      b1_oh  = '0;
      pre_b0 = '0;
      pre_b1 = '0;
      seen0  = 1'b0;
      seen1  = 1'b0;
      for (int unsigned i = 0; i < INSTR_COUNT; i++) begin
         if (vbr[i]) begin
            if (!seen0) begin
               b0_oh[i] = 1'b1;
               seen0    = 1'b1;
            end else if (!seen1) begin
               b1_oh[i] = 1'b1;
               seen1    = 1'b1;
            end
         end
         pre_b0[i] = !seen0;
         pre_b1[i] = !seen1;
      end
   end

   assign accept_take  = valid & pre_b1;
   assign accept_stall = valid & pre_b0;

endmodule

// File: rtl/rat_ckpt_ctrl.sv
// RAT checkpoint controller. Hands out checkpoints to branches in the rename
// group, retires them in order once resolved, and on a mispredict orders a
// RAT restore and reclaims every younger checkpoint.
//   clk, rst_n            : clock, async active-low reset
//   valid_i/is_branch_i   : rename group, slot 0 oldest
//   accept_o              : slots renamed this cycle
//   take_checkpoint       : RAT take strobe, with instr_to_checkpoint/alloc_id_o
//   resolve_*_i           : branch resolution from execute
//   restore_checkpoint    : RAT restore strobe, with new_checkpoint
//   free_count_o          : registered number of free checkpoints
module rat_ckpt_ctrl
   import rat_ckpt_ctrl_pkg::*;
#(
   parameter int unsigned C_NUM       = rat_ckpt_ctrl_pkg::C_NUM,
   parameter int unsigned INSTR_COUNT = rat_ckpt_ctrl_pkg::INSTR_COUNT
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic [INSTR_COUNT-1:0]   valid_i,
   input  logic [INSTR_COUNT-1:0]   is_branch_i,
   output logic [INSTR_COUNT-1:0]   accept_o,
   output logic                     take_checkpoint,
   output logic [INSTR_COUNT-1:0]   instr_to_checkpoint,
   output logic [$clog2(C_NUM)-1:0] alloc_id_o,
   input  logic                     resolve_valid_i,
   input  logic [$clog2(C_NUM)-1:0] resolve_id_i,
   input  logic                     resolve_mispredict_i,
   output logic                     restore_checkpoint,
   output logic [$clog2(C_NUM)-1:0] new_checkpoint,
   output logic [$clog2(C_NUM):0]   free_count_o
);

   localparam int unsigned IDW = $clog2(C_NUM);
   localparam int unsigned CW  = IDW + 1;
   localparam logic [CW-1:0] FULL = CW'(C_NUM);

   logic [C_NUM-1:0]       busy_q, busy_d;
   logic [C_NUM-1:0]       resolved_q, resolved_d;
   logic [IDW-1:0]         head_q, head_d;
   logic [IDW-1:0]         tail_q, tail_d;
   logic [CW-1:0]          count_q, count_d;
   logic [CW-1:0]          free_count_q;

   resolve_t               rsv;
   logic [INSTR_COUNT-1:0] b0_oh, b1_oh, accept_take, accept_stall;
   logic                   has_b0, full, rsv_legal, mispredict, do_free;
   logic [IDW-1:0]         span, young_n, young_off;

   rat_ckpt_ctrl_branch_prefix_find #(
      .INSTR_COUNT (INSTR_COUNT)
   ) u_prefix (
      .valid        (valid_i),
      .is_branch    (is_branch_i),
      .b0_oh        (b0_oh),
      .b1_oh        (b1_oh),
      .accept_take  (accept_take),
      .accept_stall (accept_stall)
   );

   assign rsv = '{valid: resolve_valid_i, id: resolve_id_i, mispredict: resolve_mispredict_i};

   assign has_b0     = |b0_oh;
   assign full       = (count_q == FULL);
   // A resolve against a non-busy entry is illegal and has no effect.
   assign rsv_legal  = rsv.valid && busy_q[rsv.id];
   assign mispredict = rsv_legal && rsv.mispredict;
   // Freeing looks only at registered state, so a slot freed now is not
   // visible to this cycle's full check.
   assign do_free    = busy_q[tail_q] && resolved_q[tail_q];

   // RAT controls and accept: combinational, consumed at the same edge.
   always_comb begin
      accept_o            = valid_i;
      take_checkpoint     = 1'b0;
      instr_to_checkpoint = '0;
      alloc_id_o          = head_q;
      restore_checkpoint  = 1'b0;
      new_checkpoint      = rsv.id;
      if (mispredict) begin
         accept_o           = '0;
         restore_checkpoint = 1'b1;
      end else if (has_b0 && !full) begin
         take_checkpoint     = 1'b1;
         instr_to_checkpoint = b0_oh;
         accept_o            = accept_take;
      end else if (has_b0) begin
         accept_o = accept_stall;
      end
   end

   always_comb begin
      busy_d     = busy_q;
      resolved_d = resolved_q;
      head_d     = head_q;
      tail_d     = tail_q;
      count_d    = count_q;
      // Entries tail..r inclusive survive a mispredict on r.
      span       = rsv.id - tail_q + IDW'(1);
      // Number of entries strictly younger than r.
      young_n    = head_q - rsv.id - IDW'(1);
      young_off  = '0;

      if (rsv_legal) begin
         resolved_d[rsv.id] = 1'b1;
      end

      if (mispredict) begin
         for (int unsigned i = 0; i < C_NUM; i++) begin
            young_off = IDW'(i) - rsv.id - IDW'(1);
            if (young_off < young_n) begin
               busy_d[i]     = 1'b0;
               resolved_d[i] = 1'b0;
            end
         end
         head_d  = rsv.id + IDW'(1);
         count_d = (span == '0 && busy_q[tail_q]) ? FULL : CW'(span);
      end else if (take_checkpoint) begin
         busy_d[head_q]     = 1'b1;
         resolved_d[head_q] = 1'b0;
         head_d             = head_q + IDW'(1);
         count_d            = count_q + CW'(1);
      end

      if (do_free) begin
         busy_d[tail_q]     = 1'b0;
         resolved_d[tail_q] = 1'b0;
         tail_d             = tail_q + IDW'(1);
         count_d            = count_d - CW'(1);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         busy_q       <= '0;
         resolved_q   <= '0;
         head_q       <= '0;
         tail_q       <= '0;
         count_q      <= '0;
         free_count_q <= FULL;
      end else begin
         busy_q       <= busy_d;
         resolved_q   <= resolved_d;
         head_q       <= head_d;
         tail_q       <= tail_d;
         count_q      <= count_d;
         free_count_q <= FULL - count_d;
      end
   end

   assign free_count_o = free_count_q;

`ifndef SYNTHESIS
   resolve_busy_a : assert property (@(posedge clk) disable iff (!rst_n)
      resolve_valid_i |-> busy_q[resolve_id_i]);
   prefix_order_a : assert property (@(posedge clk) disable iff (!rst_n)
      $onehot0(b1_oh) && ((b1_oh == '0) || has_b0));
`endif

endmodule
